// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 codes,
// access-size decode and funct3 normalisation (depends on LSU_FAULT_EN).
package lsu_pkg;

  typedef enum logic [2:0] {IDLE, RD, WR, RESP, FAULT_RESP} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Without fault checking, illegal encodings are folded onto legal ones.
  function automatic logic [2:0] norm_f3(input logic write, input logic [2:0] funct3);
`ifdef LSU_FAULT_EN
    if (write) return funct3;
    return funct3;
`else
    if (funct3 == 3'b111) return F3_D;
    if (write && funct3[2]) return {1'b0, funct3[1:0]};
    return funct3;
`endif
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment: load extraction/extension, store merge
// into a doubleword, and request fault detection (with LSU_FAULT_EN).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0] rbuf,
  input  logic [63:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  input  logic        write,
  output logic [63:0] load_data,
  output logic [63:0] store_data,
  output logic        fault
);

  logic [2:0]  eff_f3;
  logic [3:0]  size;
  logic [2:0]  off_eff;
  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] width_mask;

  assign eff_f3 = norm_f3(write, funct3);
  assign size   = size_bytes(eff_f3);

`ifdef LSU_FAULT_EN
  assign off_eff = offset;
  assign fault   = (funct3 == 3'b111) || (write && funct3[2]) ||
                   ((offset & (size[2:0] - 3'd1)) != 3'd0);
`else
  assign off_eff = offset & ~(size[2:0] - 3'd1);
  assign fault   = 1'b0;
`endif

  assign shamt   = {off_eff, 3'b000};
  assign shifted = rbuf >> shamt;

  always_comb begin
    width_mask = '1;
    case (size)
      4'd1:    width_mask = 64'h0000_0000_0000_00FF;
      4'd2:    width_mask = 64'h0000_0000_0000_FFFF;
      4'd4:    width_mask = 64'h0000_0000_FFFF_FFFF;
      default: width_mask = '1;
    endcase
  end

  always_comb begin
    load_data = shifted;
    case (eff_f3)
      F3_B:    load_data = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   load_data = {56'd0, shifted[7:0]};
      F3_HU:   load_data = {48'd0, shifted[15:0]};
      F3_WU:   load_data = {32'd0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  assign store_data = (rbuf & ~(width_mask << shamt)) | ((wdata & width_mask) << shamt);

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer onto a 64-bit data memory with registered strobes;
// sub-doubleword stores are read-modify-write. Optional: LSU_FAULT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS+2:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_fault,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  input  logic [DATA_W-1:0]     rd
);

  lsu_state_e  state_q, state_d;
  logic        write_q;
  logic [2:0]  f3_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;
  logic [63:0] rbuf;

  logic        idle;
  logic [63:0] al_rbuf, al_wdata, load_data, store_data;
  logic [2:0]  al_f3, al_off;
  logic        al_write, fault;

  assign idle = (state_q == IDLE);

  // In IDLE the aligner sees the incoming request (fault check, D-store data);
  // in RD it merges against live memory data so wd is ready at the WR edge.
  assign al_rbuf  = (state_q == RD) ? rd : rbuf;
  assign al_wdata = idle ? req_wdata : wdata_q;
  assign al_f3    = idle ? req_funct3 : f3_q;
  assign al_off   = idle ? req_addr[2:0] : off_q;
  assign al_write = idle ? req_write : write_q;

  lsu_lane_align u_align (
    .rbuf       (al_rbuf),
    .wdata      (al_wdata),
    .funct3     (al_f3),
    .offset     (al_off),
    .write      (al_write),
    .load_data  (load_data),
    .store_data (store_data),
    .fault      (fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (fault)
            state_d = FAULT_RESP;
          else if (req_write && norm_f3(req_write, req_funct3) == F3_D)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD:         state_d = write_q ? WR : RESP;
      WR:         state_d = RESP;
      RESP:       state_d = IDLE;
      FAULT_RESP: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = idle;
    resp_valid = (state_q == RESP) || (state_q == FAULT_RESP);
    resp_rdata = (state_q == RESP && !write_q) ? load_data : '0;
`ifdef LSU_FAULT_EN
    resp_fault = (state_q == FAULT_RESP);
`else
    resp_fault = 1'b0;
`endif
  end

  // Strobes are derived from the next state so they only change on edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      rbuf     <= '0;
      a        <= '0;
      wd       <= '0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
    end else begin
      if (idle && req_valid) begin
        write_q <= req_write;
        f3_q    <= req_funct3;
        off_q   <= req_addr[2:0];
        wdata_q <= req_wdata;
        if (!fault) a <= req_addr[DM_ADDRESS+2:3];
      end
      if (state_q == RD) rbuf <= rd;
      if (state_d == WR && state_q != WR) wd <= store_data;
      MemRead  <= (state_d == RD);
      MemWrite <= (state_d == WR);
    end
  end

endmodule
